// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the handshake FSM state encoding and the carry majority function.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Registered 1-bit full adder: combinational sum bit, carry kept in a flop.
// The carry is preloaded on load (1 for subtract) and advanced on en.
module serial_fa_cell
    import serial_arith_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic cin_init,
    input  logic en,
    input  logic x,
    input  logic y,
    output logic s,
    output logic carry
);

    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (load) begin
            carry <= cin_init;
        end else if (en) begin
            carry <= maj3(x, y, carry);
        end
    end

    assign s = x ^ y ^ carry;

endmodule

// File: rtl/serial_addsub_n.sv
// LSB-first bit-serial adder/subtractor with valid/ready operand and result handshakes.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_addsub_n
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             cout_q;
    logic             fa_s;
    logic             carry_q;
    logic             carry_d;
    logic             load;
    logic             step;
    logic             last;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q;
`endif

    assign load    = (state_q == IDLE) && in_valid;
    assign step    = (state_q == SHIFT);
    assign last    = (cnt_q == CNT_LAST);
    assign carry_d = maj3(opa_q[0], opb_q[0], carry_q);
    assign res_d   = {fa_s, res_q};

    serial_fa_cell u_fa (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .cin_init (sub),
        .en       (step),
        .x        (opa_q[0]),
        .y        (opb_q[0]),
        .s        (fa_s),
        .carry    (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opa_q   <= a;
                        opb_q   <= b ^ {WIDTH{sub}};
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    opa_q <= opa_q >> 1;
                    opb_q <= opb_q >> 1;
                    res_q <= res_d[WIDTH-1:1];
                    if (last) begin
                        state_q <= DONE;
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
`ifdef SERIAL_ADDSUB_OVF_EN
                        // carry_q here is still the carry into the MSB
                        ovf_q   <= carry_q ^ carry_d;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_n.sv
// Self-checking bench for serial_addsub_n (WIDTH=8) against an arithmetic reference model.
// Overflow checks are active when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub_n;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
    logic         got_ovf;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] got_sum;
    logic         got_cout;

    serial_addsub_n #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERIAL_ADDSUB_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic op);
        longint ux, uy, sx, sy, r, full, lim;
        res_t   m;
        full = longint'(1) << W;
        lim  = longint'(1) << (W - 1);
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = x[W-1] ? ux - full : ux;
        sy   = y[W-1] ? uy - full : uy;
        if (op) begin
            m.s = W'(ux - uy);
            m.c = (ux >= uy);
            r   = sx - sy;
        end else begin
            m.s = W'(ux + uy);
            m.c = ((ux + uy) >= full);
            r   = sx + sy;
        end
        m.v = (r >= lim) || (r < -lim);
        return m;
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic op, input int stall);
        res_t m;
        int   n;
        m         = model(x, y, op);
        a         = x;
        b         = y;
        sub       = op;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();
        chk("accept_busy", in_ready, 0);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
        n        = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency", n, W);
        got_sum  = sum;
        got_cout = cout;
        chk("sum", sum, m.s);
        chk("cout", cout, m.c);
`ifdef SERIAL_ADDSUB_OVF_EN
        got_ovf = ovf;
        chk("ovf", ovf, m.v);
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_busy", in_ready, 0);
            chk("stall_sum", sum, got_sum);
            chk("stall_cout", cout, got_cout);
`ifdef SERIAL_ADDSUB_OVF_EN
            chk("stall_ovf", ovf, got_ovf);
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("back_idle", in_ready, 1);
        chk("valid_low", out_valid, 0);
        chk("sum_hold", sum, got_sum);
    endtask

    initial begin
        res_t q[$];
        res_t m;
        int   got;
        int   cyc;
        int   last;
        int   seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif

        run_op(8'hFF, 8'h01, 1'b0, 0);
        chk("ff_plus_1_sum", got_sum, 8'h00);
        chk("ff_plus_1_cout", got_cout, 1);

        run_op(8'h05, 8'h07, 1'b1, 0);
        chk("5_minus_7_sum", got_sum, 8'hFE);
        chk("5_minus_7_cout", got_cout, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("5_minus_7_ovf", got_ovf, 0);

        run_op(8'h7F, 8'h01, 1'b0, 0);
        chk("7f_plus_1_sum", got_sum, 8'h80);
        chk("7f_plus_1_cout", got_cout, 0);
        chk("7f_plus_1_ovf", got_ovf, 1);

        run_op(8'h80, 8'h01, 1'b1, 0);
        chk("80_minus_1_sum", got_sum, 8'h7F);
        chk("80_minus_1_cout", got_cout, 1);
        chk("80_minus_1_ovf", got_ovf, 1);
`endif

        run_op(8'h3C, 8'hA5, 1'b0, 5);
        chk("stall_result", got_sum, 8'hE1);

        // abandon an operation on its third shift cycle
        a        = 8'hAA;
        b        = 8'h11;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("midrst_no_result", seen, 0);
        run_op(8'h12, 8'h34, 1'b0, 0);
        chk("after_rst_sum", got_sum, 8'h46);

        in_valid  = 1'b1;
        out_ready = 1'b1;
        got       = 0;
        cyc       = 0;
        last      = -1;
        while (got < 200 && cyc < 3000) begin
            if (out_valid) begin
                if (q.size() > 0) begin
                    m = q.pop_front();
                    chk("tp_sum", sum, m.s);
                    chk("tp_cout", cout, m.c);
`ifdef SERIAL_ADDSUB_OVF_EN
                    chk("tp_ovf", ovf, m.v);
`endif
                end else begin
                    chk("tp_spurious", out_valid, 0);
                end
                if (last >= 0) chk("tp_period", cyc - last, W + 2);
                last = cyc;
                got++;
            end
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom);
            if (in_ready) q.push_back(model(a, b, sub));
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("tp_count", got, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
